// File: rtl/result_page_sequencer_pkg.sv
// Shared types and helpers for the result page sequencer.
package rps_pkg;

  // FSM states; encodings are fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW_LO = 2'd2,
    SHOW_HI = 2'd3
  } state_e;

  localparam logic PAGE_LO = 1'b0;
  localparam logic PAGE_HI = 1'b1;

  // Four hex digit nibbles, most significant digit first.
  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  // Split a 16-bit half of the snapshot into its display digits.
  function automatic digits_t nibbles_of(input logic [15:0] half);
    digits_t d;
    d.ones      = half[3:0];
    d.tens      = half[7:4];
    d.hundreds  = half[11:8];
    d.thousands = half[15:12];
    return d;
  endfunction

endpackage

// File: rtl/result_page_sequencer_rise_detect.sv
// Registered level with a combinational rising-edge pulse.
module rise_detect (
  input  logic clk_10Hz,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level;

  // Track the level every cycle so a held input never re-triggers.
  always_ff @(posedge clk_10Hz or posedge reset) begin
    if (reset) begin
      r_level <= 1'b0;
    end else begin
      r_level <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level;

endmodule

// File: rtl/result_page_sequencer.sv
// Freezes the core Result on halt and pages its two 16-bit halves to the display.
module result_page_sequencer
  import rps_pkg::*;
#(
  parameter int unsigned DWELL_TICKS  = 20,
  parameter bit          SKIP_ZERO_HI = 1'b1
) (
  input  logic        clk_10Hz,
  input  logic        reset,
  input  logic        hlt,
  input  logic [31:0] Result,
  input  logic        btn_next,
  input  logic        auto_en,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        page,
  output logic        disp_valid,
  output logic        hi_nonzero
);

  localparam int unsigned DwellW = $clog2(DWELL_TICKS);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_TICKS - 1);

  state_e              r_state;
  logic [31:0]         r_snapshot;
  digits_t             r_digits;
  logic                r_page;
  logic                r_disp_valid;
  logic                r_hi_nonzero;
  logic [DwellW-1:0]   r_dwell;

  logic                w_btn_rise;
  logic [15:0]         w_other_half;
  logic                w_dwell_done;
  logic                w_skip_hi;

  rise_detect u_btn_rise (
    .clk_10Hz (clk_10Hz),
    .reset    (reset),
    .i_level  (btn_next),
    .o_rise   (w_btn_rise)
  );

  // Half that becomes visible on the next page toggle.
  assign w_other_half = (r_state == SHOW_LO) ? r_snapshot[31:16] : r_snapshot[15:0];
  assign w_dwell_done = (r_dwell == DwellLast);
  // Auto-advance must not land on an all-zero HI page when skipping is enabled.
  assign w_skip_hi    = SKIP_ZERO_HI && (r_snapshot[31:16] == 16'h0) && (r_state == SHOW_LO);

  // Main sequencer: state, snapshot, dwell timer and registered display outputs.
  always_ff @(posedge clk_10Hz or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_snapshot   <= '0;
      r_digits     <= '0;
      r_page       <= PAGE_LO;
      r_disp_valid <= 1'b0;
      r_hi_nonzero <= 1'b0;
      r_dwell      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_digits     <= '0;
          r_page       <= PAGE_LO;
          r_disp_valid <= 1'b0;
          r_hi_nonzero <= 1'b0;
          r_dwell      <= '0;
          if (hlt) begin
            r_state <= CAPTURE;
          end
        end

        CAPTURE: begin
          r_dwell <= '0;
          if (hlt) begin
            r_snapshot   <= Result;
            r_digits     <= nibbles_of(Result[15:0]);
            r_page       <= PAGE_LO;
            r_disp_valid <= 1'b1;
            r_hi_nonzero <= |Result[31:16];
            r_state      <= SHOW_LO;
          end else begin
            r_digits     <= '0;
            r_page       <= PAGE_LO;
            r_disp_valid <= 1'b0;
            r_hi_nonzero <= 1'b0;
            r_state      <= IDLE;
          end
        end

        SHOW_LO, SHOW_HI: begin
          if (!hlt) begin
            r_digits     <= '0;
            r_page       <= PAGE_LO;
            r_disp_valid <= 1'b0;
            r_hi_nonzero <= 1'b0;
            r_dwell      <= '0;
            r_state      <= IDLE;
          end else if (w_btn_rise || (auto_en && w_dwell_done && !w_skip_hi)) begin
            // Button wins over a coincident dwell expiry; either way one toggle.
            r_digits <= nibbles_of(w_other_half);
            r_page   <= (r_state == SHOW_LO) ? PAGE_HI : PAGE_LO;
            r_state  <= (r_state == SHOW_LO) ? SHOW_HI : SHOW_LO;
            r_dwell  <= '0;
          end else if (auto_en && w_dwell_done) begin
            r_dwell <= '0;
          end else if (auto_en) begin
            r_dwell <= r_dwell + 1'b1;
          end else begin
            r_dwell <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ones       = r_digits.ones;
  assign tens       = r_digits.tens;
  assign hundreds   = r_digits.hundreds;
  assign thousands  = r_digits.thousands;
  assign page       = r_page;
  assign disp_valid = r_disp_valid;
  assign hi_nonzero = r_hi_nonzero;

endmodule

// File: tb/tb_result_page_sequencer.sv
// Self-checking bench for result_page_sequencer against a page-level reference model.
module tb_result_page_sequencer;

  localparam int unsigned Dwell = 20;

  logic        clk_10Hz;
  logic        reset;
  logic        hlt;
  logic [31:0] Result;
  logic        btn_next;
  logic        auto_en;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic        page, disp_valid, hi_nonzero;

  int n_vec;
  int n_err;

  // Reference model: what the viewer should see, tracked at page granularity.
  int          m_mode;   // 0 waiting for halt, 1 halt seen, 2 showing
  logic [31:0] m_snap;
  logic        m_page;
  logic        m_valid;
  int          m_dwell;
  logic        m_btn_prev;

  logic [18:0] w_obs;
  assign w_obs = {thousands, hundreds, tens, ones, page, disp_valid, hi_nonzero};

  result_page_sequencer #(
    .DWELL_TICKS  (Dwell),
    .SKIP_ZERO_HI (1'b1)
  ) dut (
    .clk_10Hz   (clk_10Hz),
    .reset      (reset),
    .hlt        (hlt),
    .Result     (Result),
    .btn_next   (btn_next),
    .auto_en    (auto_en),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .page       (page),
    .disp_valid (disp_valid),
    .hi_nonzero (hi_nonzero)
  );

  initial clk_10Hz = 1'b0;
  always #5 clk_10Hz = ~clk_10Hz;

  task automatic m_reset();
    m_mode     = 0;
    m_snap     = '0;
    m_page     = 1'b0;
    m_valid    = 1'b0;
    m_dwell    = 0;
    m_btn_prev = 1'b0;
  endtask

  task automatic m_step();
    bit pressed;
    pressed = btn_next && !m_btn_prev;
    if (m_mode == 0) begin
      if (hlt) m_mode = 1;
    end else if (m_mode == 1) begin
      if (hlt) begin
        m_snap  = Result;
        m_page  = 1'b0;
        m_valid = 1'b1;
        m_dwell = 0;
        m_mode  = 2;
      end else begin
        m_mode = 0;
      end
    end else begin
      if (!hlt) begin
        m_mode  = 0;
        m_valid = 1'b0;
        m_page  = 1'b0;
        m_dwell = 0;
      end else if (pressed) begin
        m_page  = !m_page;
        m_dwell = 0;
      end else if (auto_en) begin
        if (m_dwell == Dwell - 1) begin
          if (!(m_snap[31:16] == 0 && !m_page)) m_page = !m_page;
          m_dwell = 0;
        end else begin
          m_dwell = m_dwell + 1;
        end
      end else begin
        m_dwell = 0;
      end
    end
    m_btn_prev = btn_next;
  endtask

  function automatic logic [18:0] m_expect();
    logic [15:0] h;
    if (!m_valid) return '0;
    h = m_page ? m_snap[31:16] : m_snap[15:0];
    return {h, m_page, 1'b1, m_snap[31:16] != 16'h0};
  endfunction

  // One active edge, then settle before anyone samples.
  task automatic tick();
    @(posedge clk_10Hz);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hlt = 1'b0; Result = '0; btn_next = 1'b0; auto_en = 1'b0;
    m_reset();
    #12;
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL reset_state: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    @(negedge clk_10Hz);
    reset = 1'b0;
  endtask

  task automatic test_capture();
    logic [18:0] exp_v;
    Result = 32'h1234_ABCD;
    hlt    = 1'b1;
    tick();
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL capture_latency: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    tick();
    exp_v = {4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL capture_lo: got %h expected %h", w_obs, exp_v); n_err++;
    end
    Result = 32'h0;
    repeat (3) tick();
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL snapshot_frozen: got %h expected %h", w_obs, exp_v); n_err++;
    end
  endtask

  task automatic test_button();
    logic [18:0] exp_v;
    auto_en  = 1'b0;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    exp_v = {4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 1'b1};
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL button_to_hi: got %h expected %h", w_obs, exp_v); n_err++;
    end
    tick();
    btn_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (w_obs !== m_expect()) begin
        $display("FAIL button_held_%0d: got %h expected %h", i, w_obs, m_expect()); n_err++;
      end
    end
    btn_next = 1'b0;
    tick();
    n_vec++;
    if (page !== 1'b0) begin
      $display("FAIL button_held_single_toggle: page got %b expected 0", page); n_err++;
    end
  endtask

  task automatic test_auto();
    logic prev;
    int   toggles[$];
    int   gap;
    auto_en = 1'b1;
    prev = page;
    for (int t = 1; t <= 59; t++) begin
      tick();
      if (page !== prev) toggles.push_back(t);
      prev = page;
      n_vec++;
      if (w_obs !== m_expect()) begin
        $display("FAIL auto_track_%0d: got %h expected %h", t, w_obs, m_expect()); n_err++;
      end
    end
    n_vec++;
    if (toggles.size() != 2 || toggles[0] != 20 || toggles[1] != 40) begin
      $display("FAIL auto_period: got %0d toggles (first at %0d) expected toggles at 20 and 40",
               toggles.size(), (toggles.size() > 0) ? toggles[0] : -1);
      n_err++;
    end
    // Button pressed on the edge where the dwell also expires.
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    n_vec++;
    if (page !== 1'b1) begin
      $display("FAIL button_and_dwell: page got %b expected 1", page); n_err++;
    end
    gap = 0;
    prev = page;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (page !== prev && gap == 0) gap = t;
      prev = page;
    end
    n_vec++;
    if (gap != 20) begin
      $display("FAIL dwell_restart: next toggle after %0d edges expected 20", gap); n_err++;
    end
    auto_en = 1'b0;
  endtask

  task automatic test_skip_zero();
    logic [18:0] exp_v;
    hlt = 1'b0;
    tick();
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL halt_drop_clear: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    Result = 32'h0000_00FF;
    hlt    = 1'b1;
    tick();
    tick();
    exp_v = {4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL capture_zero_hi: got %h expected %h", w_obs, exp_v); n_err++;
    end
    auto_en = 1'b1;
    for (int t = 1; t <= 65; t++) begin
      tick();
      n_vec++;
      if (w_obs !== exp_v) begin
        $display("FAIL skip_zero_hi_%0d: got %h expected %h", t, w_obs, exp_v); n_err++;
      end
    end
    auto_en  = 1'b0;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    exp_v = {16'h0, 1'b1, 1'b1, 1'b0};
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL button_zero_hi: got %h expected %h", w_obs, exp_v); n_err++;
    end
  endtask

  task automatic test_recapture();
    logic [18:0] exp_v;
    tick();
    hlt = 1'b0;
    tick();
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL hi_halt_drop: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    Result = 32'hDEAD_BEEF;
    hlt    = 1'b1;
    tick();
    tick();
    exp_v = {4'hB, 4'hE, 4'hE, 4'hF, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (w_obs !== exp_v) begin
      $display("FAIL recapture: got %h expected %h", w_obs, exp_v); n_err++;
    end
  endtask

  task automatic test_async_reset();
    auto_en = 1'b1;
    repeat (7) tick();
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL async_reset: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    #2;
    reset  = 1'b0;
    Result = $urandom;
    tick();
    n_vec++;
    if (w_obs !== 19'h0) begin
      $display("FAIL post_reset_latency: got %h expected %h", w_obs, 19'h0); n_err++;
    end
    tick();
    n_vec++;
    if (w_obs !== m_expect() || disp_valid !== 1'b1) begin
      $display("FAIL post_reset_capture: got %h expected %h", w_obs, m_expect()); n_err++;
    end
    auto_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      hlt    = ($urandom_range(0, 24) != 0);
      Result = $urandom;
      if ($urandom_range(0, 3) == 0)  btn_next = ~btn_next;
      if ($urandom_range(0, 59) == 0) auto_en  = ~auto_en;
      tick();
      n_vec++;
      if (w_obs !== m_expect()) begin
        $display("FAIL random_%0d: got %h expected %h", i, w_obs, m_expect()); n_err++;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_capture();
    test_button();
    test_auto();
    test_skip_zero();
    test_recapture();
    test_async_reset();
    auto_en = 1'b1;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_page_sequencer.md
Name: result_page_sequencer

Overview:
- Controls display of the 32-bit processor Result on the 4-digit hex display once the core halts.
- Freezes a snapshot of Result when hlt rises. Pages the snapshot out as two 16-bit halves, LO = Result[15:0] and HI = Result[31:16].
- Pages advance on a pushbutton or on an auto-advance dwell timer.
- Sits between the core (Result, hlt) and the seven-segment decoder, which consumes ones, tens, hundreds and thousands.

Parameters:
- DWELL_TICKS, 20, clk_10Hz cycles per page in auto mode (20 = 2 s). Legal range 2..255.
- SKIP_ZERO_HI, 1, when 1, auto-advance never enters HI if snapshot[31:16] == 0.

Ports:
- clk_10Hz  in  1  system display clock, 10 Hz
- reset  in  1  asynchronous, active-high
- hlt  in  1  core halted, level
- Result  in  32  core result bus
- btn_next  in  1  page-advance button, already debounced, level
- auto_en  in  1  enable auto-advance, level
- ones  out  4  digit 0 nibble
- tens  out  4  digit 1 nibble
- hundreds  out  4  digit 2 nibble
- thousands  out  4  digit 3 nibble
- page  out  1  0 = LO half shown, 1 = HI half shown
- disp_valid  out  1  digits hold snapshot data
- hi_nonzero  out  1  snapshot[31:16] != 0

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is clk_10Hz. All other logic is synchronous to the clk_10Hz rising edge.
- Reset: state = IDLE. snapshot, all digits, page, disp_valid, hi_nonzero, dwell counter and btn_q all = 0.
- States are IDLE, CAPTURE, SHOW_LO and SHOW_HI.
- btn_q registers btn_next in every state. btn_rise = btn_next & ~btn_q.
- IDLE:
  - Outputs held at 0.
  - Edge with hlt = 1 -> CAPTURE.
- CAPTURE, one cycle:
  - Next edge: snapshot <= Result and digits <= Result[15:0] (ones = [3:0], tens = [7:4], hundreds = [11:8], thousands = [15:12]).
  - At the same edge: page <= 0, disp_valid <= 1, hi_nonzero <= |Result[31:16], dwell <= 0, state -> SHOW_LO.
  - If hlt = 0 at this edge -> IDLE with outputs cleared; no capture.
  - Latency: digits are valid 2 edges after the first edge that samples hlt = 1.
- SHOW_LO / SHOW_HI, priority highest first:
  1. hlt = 0 -> IDLE. At the same edge, all digits, page, disp_valid and hi_nonzero <= 0, and dwell <= 0.
  2. btn_rise -> toggle page, load digits from the other snapshot half, dwell <= 0. SKIP_ZERO_HI does not block the button.
  3. auto_en = 1 and dwell == DWELL_TICKS-1:
     - Toggle page and reload digits as in rule 2. dwell <= 0.
     - Exception: SKIP_ZERO_HI = 1, snapshot[31:16] == 0 and in SHOW_LO. Stay in SHOW_LO with dwell <= 0.
  4. auto_en = 1, otherwise: dwell <= dwell + 1.
  5. auto_en = 0: dwell <= 0 and page is held.
- Boundary conditions:
  - Button edge and dwell expiry on the same edge: exactly one toggle; the button rule wins.
  - Button held continuously: one toggle only.
  - Button already held when SHOW_LO is entered: no toggle, because btn_q tracks it in all states.
  - Result changes while in SHOW: ignored, since the display shows the frozen snapshot.
  - hlt drops then rises again: a fresh capture via IDLE -> CAPTURE. There is always at least one IDLE cycle between captures.
  - Reset asserted mid-SHOW: immediate asynchronous clear to reset values.
- Dwell counter width is $clog2(DWELL_TICKS). It never exceeds DWELL_TICKS-1.

Decomposition:
- Package rps_pkg holds:
  - State encoding localparams (IDLE = 2'd0, CAPTURE = 2'd1, SHOW_LO = 2'd2, SHOW_HI = 2'd3).
  - PAGE_LO = 1'b0 and PAGE_HI = 1'b1.
  - Function nibbles_of(half[15:0]), which returns the four digit nibbles.
- One sub-module, rise_detect: a registered level plus rising-edge pulse with asynchronous reset. Used for btn_next.
- FSM, snapshot and dwell counter stay in the top module.

Test Plan:
1. Reset, then Result = 32'h1234_ABCD, hlt 0 -> 1 -> 2 edges later ones = D, tens = C, hundreds = B, thousands = A, page = 0, disp_valid = 1, hi_nonzero = 1. Result changed to 32'h0 afterwards -> digits unchanged.
2. Same snapshot, auto_en = 0, single-cycle btn_next pulse -> next edge digits = 4, 3, 2, 1 and page = 1. Button held 5 cycles -> one toggle only.
3. auto_en = 1, DWELL_TICKS = 20 -> page toggles exactly every 20 edges (LO -> HI -> LO). Button pulse coinciding with the 20th edge -> single toggle and dwell restarts.
4. SKIP_ZERO_HI = 1, Result = 32'h0000_00FF, auto_en = 1 -> page stays 0 for more than 60 edges and hi_nonzero = 0. btn_next pulse -> page = 1, all digits 0.
5. In SHOW_HI, hlt -> 0 -> next edge all outputs 0 and state IDLE. Result = 32'hDEAD_BEEF, hlt -> 1 -> new capture shows digits F, E, E, B with page = 0.
6. Reset asserted asynchronously mid-SHOW with a nonzero dwell -> outputs 0 immediately, before the next edge. After release with hlt = 1 -> capture proceeds with the 2-edge latency.
